confreg_uart_tx: RTL and testbench

- UART transmitter that serialises the byte stream produced by the confreg UART write port (write_uart_valid / write_uart_data) onto a physical tx pin.
- Sits between confreg and the board UART pin inside soc_top.
- Buffers CPU writes in a small FIFO so back-to-back stores are not lost.
- Emits 8N1 frames (8 data bits, no parity, 1 stop bit), LSB first.

---
 rtl/uart_pkg.sv | 6 +
 rtl/confreg_uart_tx_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 43 ++++
 rtl/confreg_uart_tx.sv | 93 +++++++++
 tb/tb_confreg_uart_tx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the confreg UART transmitter
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int CLKS_PER_BIT_DEF = 868;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/confreg_uart_tx_if.sv
// confreg_uart_tx_if: byte write handshake between confreg and the UART transmitter
//   wr_valid : byte offered (master -> slave)
//   wr_data  : byte to send (master -> slave)
//   wr_ready : slave can accept a byte this cycle (slave -> master)
interface confreg_uart_tx_if;
  import uart_pkg::*;
  logic wr_valid;
  logic [UART_DATA_W-1:0] wr_data;
  logic wr_ready;
  modport master (output wr_valid, wr_data, input wr_ready);
  modport slave (input wr_valid, wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with push/pop, full/empty flags and occupancy count
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din when not full
//   pop, dout  : dout shows the head; pop advances it when not empty
//   full, empty, count : occupancy status from the registered count
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign full = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign count = r_count;
  assign dout = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop = pop && !empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
endmodule

// File: rtl/confreg_uart_tx.sv
// confreg_uart_tx: FIFO-buffered 8N1 UART transmitter fed by the confreg UART write port
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr (slave)  : wr_valid/wr_data/wr_ready byte push handshake
//   tx          : registered serial line, idle high, LSB first
//   busy        : frame in progress or bytes queued
//   fifo_count  : bytes currently queued
//   overflow    : sticky, set when a push is dropped on a full FIFO; ovf_clr clears (set wins)
//   Build option CONFREG_UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module confreg_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  confreg_uart_tx_if.slave              wr,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  tx_state_t r_state, w_nxt;
  logic [BW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [UART_DATA_W-1:0] r_shift, w_shift_nxt, w_head;
  logic r_tx, w_tx_nxt, r_ovf, w_tick, w_push, w_pop, w_full, w_empty;
`ifdef CONFREG_UART_TX_PARITY_EN
  logic r_par, w_par_nxt;
`endif
  assign w_tick = r_cnt == BW'(CLKS_PER_BIT - 1);
  assign w_push = wr.wr_valid && !w_full;
  // Pop from IDLE, or at the last stop-bit cycle so frames run back to back
  assign w_pop = !w_empty && (r_state == IDLE || (r_state == STOP && w_tick));
  assign wr.wr_ready = !w_full;
  assign tx = r_tx;
  assign overflow = r_ovf;
  assign busy = r_state != IDLE || !w_empty;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_push), .pop(w_pop), .din(wr.wr_data),
    .dout(w_head), .full(w_full), .empty(w_empty), .count(fifo_count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:   w_nxt = w_empty ? IDLE : START;
      START:  w_nxt = w_tick ? DATA : START;
`ifdef CONFREG_UART_TX_PARITY_EN
      DATA:   w_nxt = (w_tick && r_bit == 3'd7) ? PARITY : DATA;
      PARITY: w_nxt = w_tick ? STOP : PARITY;
`else
      DATA:   w_nxt = (w_tick && r_bit == 3'd7) ? STOP : DATA;
`endif
      STOP:   w_nxt = !w_tick ? STOP : w_empty ? IDLE : START;
      default: w_nxt = IDLE;
    endcase
  end
  // tx is computed from the next state and registered, so the pin never glitches
  always_comb begin
    w_shift_nxt = w_pop ? w_head : (r_state == DATA && w_tick) ? r_shift >> 1 : r_shift;
`ifdef CONFREG_UART_TX_PARITY_EN
    w_par_nxt = w_pop ? ^w_head : r_par;
    w_tx_nxt = w_nxt == START ? 1'b0 : w_nxt == DATA ? w_shift_nxt[0] : w_nxt == PARITY ? w_par_nxt : 1'b1;
`else
    w_tx_nxt = w_nxt == START ? 1'b0 : w_nxt == DATA ? w_shift_nxt[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_tx <= 1'b1;
      r_ovf <= 1'b0;
`ifdef CONFREG_UART_TX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      r_cnt <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      r_bit <= w_pop ? '0 : (r_state == DATA && w_tick) ? r_bit + 1'b1 : r_bit;
      r_shift <= w_shift_nxt;
      r_tx <= w_tx_nxt;
      r_ovf <= (wr.wr_valid && w_full) ? 1'b1 : ovf_clr ? 1'b0 : r_ovf;
`ifdef CONFREG_UART_TX_PARITY_EN
      r_par <= w_par_nxt;
`endif
    end
endmodule

// File: tb/tb_confreg_uart_tx.sv
// tb_confreg_uart_tx: randomized scoreboard bench for confreg_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_confreg_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef CONFREG_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic clk = 0, rst_n = 0, ovf_clr = 0;
  logic tx, busy, overflow;
  logic [2:0] fifo_count;
  confreg_uart_tx_if ifc();

  confreg_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr(ifc.slave), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: queue occupancy plus cycles left in the current frame.
  // A byte leaves the queue when the line is idle or on the last cycle of a frame.
  int m_count = 0, m_left = 0;
  logic m_ovf = 0;
  logic [7:0] exp_q[$];
  logic m_acc, m_pop;
  assign m_acc = ifc.wr_valid && m_count < DEPTH;
  assign m_pop = m_count > 0 && m_left <= 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_count <= 0;
      m_left <= 0;
      m_ovf <= 0;
      exp_q.delete();
    end else begin
      if (m_acc) exp_q.push_back(ifc.wr_data);
      m_count <= m_count + int'(m_acc) - int'(m_pop);
      m_left <= m_pop ? FRAME : (m_left > 0 ? m_left - 1 : 0);
      m_ovf <= (ifc.wr_valid && !m_acc) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    end

  int vecs = 0, errs = 0, timeouts = 0;
  logic done = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle status checks against the model, and a line decoder
  // that rebuilds each frame from mid-bit samples and pops the scoreboard.
  initial begin : monitor
    logic mon_act, prev_tx;
    int mon_cnt, p;
    logic [7:0] mon_byte;
    mon_act = 0;
    prev_tx = 1;
    mon_cnt = 0;
    mon_byte = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wr_ready", ifc.wr_ready, 1);
        mon_act = 0;
        prev_tx = 1;
      end else begin
        chk("fifo_count", fifo_count, m_count);
        chk("wr_ready", ifc.wr_ready, m_count != DEPTH);
        chk("busy", busy, m_left != 0 || m_count != 0);
        chk("overflow", overflow, m_ovf);
        if (m_left == 0) chk("idle_tx", tx, 1);
        if (m_left == FRAME) chk("start_latency", tx, 0);
        if (!mon_act) begin
          if (prev_tx && !tx) begin
            mon_act = 1;
            mon_cnt = 0;
          end
        end else mon_cnt++;
        if (mon_act && mon_cnt % CPB == CPB / 2) begin
          p = mon_cnt / CPB;
          if (p == 0) chk("start_bit", tx, 0);
          else if (p <= 8) mon_byte[p-1] = tx;
          else if (p < NB - 1) chk("parity_bit", tx, ^mon_byte);
          else begin
            chk("stop_bit", tx, 1);
            if (exp_q.size() == 0) chk("unexpected_frame", mon_byte, 32'hFFFF_FFFF);
            else chk("frame_data", mon_byte, exp_q.pop_front());
            mon_act = 0;
          end
        end
        prev_tx = tx;
      end
      if (done) begin
        chk("queue_drained", exp_q.size(), 0);
        chk("decoder_idle", mon_act, 0);
        chk("wait_timeouts", timeouts, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    ifc.wr_valid = 1;
    ifc.wr_data = d;
    @(negedge clk);
    ifc.wr_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_count == 0 && m_left == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeouts++;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_left(input int l);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_left == l) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeouts++;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    ifc.wr_valid = 0;
    ifc.wr_data = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // single byte from idle
    push(8'h55);
    wait_idle();
    // back-to-back frames
    push(8'h41);
    push(8'h42);
    push(8'h43);
    wait_idle();
    // fill while first frame in flight, then drops while full
    for (int i = 0; i < 7; i++) push(8'($urandom));
    repeat (5) @(negedge clk);
    ovf_clr = 1;
    ifc.wr_valid = 1;
    ifc.wr_data = 8'hEE;
    @(negedge clk);
    ifc.wr_valid = 0;
    @(negedge clk);
    ovf_clr = 0;
    @(negedge clk);
    wait_idle();
    // push attempted on the edge a full FIFO pops
    for (int i = 0; i < 5; i++) push(8'($urandom));
    wait_left(1);
    ifc.wr_valid = 1;
    ifc.wr_data = 8'h99;
    @(negedge clk);
    ifc.wr_valid = 0;
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    wait_idle();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      ifc.wr_valid = ($urandom % 4) == 0;
      ifc.wr_data = 8'($urandom);
      ovf_clr = ($urandom % 8) == 0;
      @(negedge clk);
    end
    ifc.wr_valid = 0;
    ovf_clr = 0;
    wait_idle();
    // asynchronous reset during data bit 3 of 0x00 with a second byte queued
    push(8'h00);
    push(8'hFF);
    wait_left(FRAME - 17);
    @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    push(8'hA5);
    wait_idle();
    done = 1;
  end
endmodule
